rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one burst-capable resource (a shared bus or memory port) among NUM_PORTS requesters.
- Unlike a single-cycle arbiter, it locks the grant to one owner for a whole burst.
- The grant is released on the owner's last beat, on a beat-count cap, or when the owner abandons its request.
- It sits between requester front-ends and the shared resource. The resource reports accepted beats back via beat_i.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- MAX_BEATS, 8, maximum beats per grant before forced release (1..255).
- TIMEOUT, 16, maximum stall cycles with no beat before forced release; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- req_i  input  NUM_PORTS  per-port request level; held high until the port's burst is done.
- last_i  input  NUM_PORTS  per-port flag marking the final beat of the current burst.
- beat_i  input  1  resource accepted one beat from the current owner this cycle.
- gnt_o  output  NUM_PORTS  registered one-hot grant; all zero when no owner.
- gnt_id_o  output  $clog2(NUM_PORTS)  binary index of owner; valid when busy_o=1.
- busy_o  output  1  an owner holds the resource.
- release_o  output  1  one-cycle pulse on the cycle a grant ends.
- timeout_o  output  1  one-cycle pulse when a release is caused by timeout.

Behaviour:
- Reset values: state=IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, release_o=0, timeout_o=0, beat_cnt=0.
- Reset values: priority pointer ptr=0, meaning port 0 is highest priority first.
- All outputs are registered.
- The FSM has two states, IDLE and OWN.
- IDLE:
  - If |req_i, pick the first requesting port scanning upward from ptr, wrapping modulo NUM_PORTS.
  - Next cycle: state=OWN, gnt_o=onehot(sel), gnt_id_o=sel, busy_o=1, beat_cnt=0.
  - Grant latency from request to gnt_o is 1 cycle.
  - beat_i is ignored in IDLE.
- OWN: when beat_i=1, beat_cnt increments. beat_cnt has width $clog2(MAX_BEATS+1) and never wraps.
- Release conditions in OWN, evaluated each cycle:
  - (a) beat_i & last_i[owner];
  - (b) beat_i with beat_cnt==MAX_BEATS-1, i.e. the cap is reached on this beat;
  - (c) req_i[owner]==0 (abandon);
  - (d) timeout, only with the macro.
- On release:
  - release_o=1 next cycle.
  - ptr = owner+1, modulo NUM_PORTS.
  - The arbitration decision is made in the same cycle using the new ptr over the current req_i.
- After release, if another port is requesting:
  - gnt_o switches directly to the new owner next cycle.
  - No dead cycle; state stays OWN; beat_cnt=0.
- After release, if the only requester is the old owner with req still high (case a/b):
  - It is re-granted after a full scan, since it has lowest priority now.
  - gnt_o stays set, and release_o still pulses.
- After release with no requests: next cycle state=IDLE, gnt_o=0, busy_o=0.
- Simultaneous release conditions: at most one release per cycle. Priority for timeout_o attribution is (a)/(b) before (c) before (d).
- Non-owner req_i/last_i changes never affect the current grant. No preemption by other ports.
- last_i of non-owners is ignored.
- Reset asserted mid-burst: immediate return to reset values. No release_o pulse.
- gnt_o is always one-hot or zero; the bench checks this every cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A stall counter counts consecutive OWN cycles with beat_i=0. It clears on any beat and on any new grant.
  - When it reaches TIMEOUT-1 with beat_i=0, the grant is released as condition (d).
  - timeout_o pulses with release_o.
- When undefined: there is no stall counter, timeout_o is tied 0, and TIMEOUT is unused.

Test Plan:
- Reset, then req_i=4'b0101, port 0 sends 3 beats with last on the 3rd:
  - gnt_o=0001 one cycle after req;
  - release_o pulse after the 3rd beat;
  - gnt_o=0100 on the next cycle with no gap.
- req_i=4'b1111 held, each port sends 1 beat with last:
  - grant order 0,1,2,3,0;
  - gnt_id_o follows that order;
  - never two bits set.
- Port 2 alone, 10 beats, last_i never set, MAX_BEATS=8:
  - release after the 8th beat;
  - re-grant to port 2 (gnt_o stays 0100);
  - beat_cnt restarts at 0.
- Owner port 1 drops req_i mid-burst with req_i[3]=1:
  - next cycle gnt_o=1000 and release_o=1.
- ARB_TIMEOUT_EN, TIMEOUT=16, owner port 0 with no beats:
  - release and timeout_o=1 after 16 OWN cycles;
  - without the macro, the grant holds indefinitely and timeout_o=0.
- Reset pulsed during a burst with gnt_o=0010:
  - outputs zero immediately;
  - after reset with req_i=4'b0010, port 1 is granted with ptr back at 0.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Round-robin arbiter for one burst-capable shared resource. Once a port
//   is granted, it keeps the grant for its whole burst. The grant ends on
//   any of these:
//     - the owner's last beat,
//     - reaching the beat cap,
//     - the owner dropping its request,
//     - optionally, a stall timeout.
//   When one grant ends, the next owner is picked in the same cycle, so
//   the resource never sees a dead cycle.
//
// Build option:
//   ARB_TIMEOUT_EN - enables the stall counter and timeout release.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   req_i      per-port request level
//   last_i     per-port last-beat flag (only the owner's bit matters)
//   beat_i     the resource accepted a beat from the owner this cycle
//   gnt_o      registered one-hot grant, zero when there is no owner
//   gnt_id_o   binary owner index, valid while busy_o is high
//   busy_o     an owner holds the resource
//   release_o  one-cycle pulse on the cycle after a grant ends
//   timeout_o  one-cycle pulse, coincident with release_o, when the
//              release was caused by a stall timeout
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no owner; scanning req_i from ptr
// ST_OWN   | gnt_id_q owns the resource; counting beats
module rr_burst_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BEATS = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [NUM_PORTS-1:0]         last_i,
  input  logic                         beat_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
  output logic                         busy_o,
  output logic                         release_o,
  output logic                         timeout_o
);

  localparam int ID_W  = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic [CNT_W-1:0] CAP_M1  = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(MAX_BEATS);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PORTS - 1);
  localparam logic [ID_W:0]    NP      = (ID_W + 1)'(NUM_PORTS);

  logic [0:0]           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 busy_q, busy_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 rel_q, rel_d;
  logic                 to_q, to_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ID_W-1:0]      owner_next;
  logic [ID_W-1:0]      scan_base;
  logic [2*NUM_PORTS-1:0] req_rot;
  logic                 sel_found;
  logic [ID_W-1:0]      sel_off;
  logic [ID_W:0]        sel_sum;
  logic [ID_W-1:0]      sel_id;

  logic rel_ab, rel_c, rel_tmo, release_now;

  assign owner_next = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

  // On a release the winner is chosen with the already-advanced pointer,
  // so the departing owner ends up with lowest priority.
  assign scan_base = (state_q == ST_OWN) ? owner_next : ptr_q;
  assign req_rot   = {req_i, req_i} >> scan_base;

  always_comb begin
    sel_found = 1'b0;
    sel_off   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!sel_found && req_rot[i]) begin
        sel_found = 1'b1;
        sel_off   = ID_W'(i);
      end
    end
    sel_sum = {1'b0, scan_base} + {1'b0, sel_off};
    if (sel_sum >= NP) sel_sum = sel_sum - NP;
    sel_id = sel_sum[ID_W-1:0];
  end

  assign rel_ab = beat_i & (last_i[id_q] | (cnt_q == CAP_M1));
  assign rel_c  = ~req_i[id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_M1 = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  assign rel_tmo = ~beat_i & (stall_q == STALL_M1);

  // Counts consecutive beat-less OWN cycles; any beat or any new grant
  // (including the re-grant that follows a release) restarts it.
  always_comb begin
    stall_d = '0;
    if (state_q == ST_OWN && !beat_i && !release_now) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign rel_tmo        = 1'b0;
`endif

  assign release_now = (state_q == ST_OWN) & (rel_ab | rel_c | rel_tmo);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rel_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d = ST_OWN;
          id_d    = sel_id;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        if (release_now) begin
          rel_d = 1'b1;
          // Timeout is credited only when nothing else explains the release.
          to_d  = rel_tmo & ~rel_ab & ~rel_c;
          ptr_d = owner_next;
          cnt_d = '0;
          if (sel_found) begin
            id_d = sel_id;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else if (beat_i && cnt_q < CAP) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    gnt_d = busy_d ? (NUM_PORTS'(1) << id_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      rel_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      gnt_q   <= gnt_d;
      rel_q   <= rel_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign busy_o    = busy_q;
  assign release_o = rel_q;
  assign timeout_o = to_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Testbench for rr_burst_arbiter (NUM_PORTS=4, MAX_BEATS=8, TIMEOUT=16).
// Expected values follow the ARB_TIMEOUT_EN setting of the build.
module tb_rr_burst_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] last_i = '0;
  logic       beat_i = 1'b0;
  logic [3:0] gnt_o;
  logic [1:0] gnt_id_o;
  logic       busy_o;
  logic       release_o;
  logic       timeout_o;

  int n_chk = 0;
  int n_err = 0;

  rr_burst_arbiter #(.NUM_PORTS(4), .MAX_BEATS(8), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .last_i    (last_i),
    .beat_i    (beat_i),
    .gnt_o     (gnt_o),
    .gnt_id_o  (gnt_id_o),
    .busy_o    (busy_o),
    .release_o (release_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] last;
    logic       beat;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       rel;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] last, input logic beat,
                     input logic [3:0] gnt, input logic [1:0] id, input logic busy,
                     input logic rel, input logic to);
    tbl.push_back('{1'b0, req, last, beat, gnt, id, busy, rel, to});
  endtask

  task automatic addrst();
    tbl.push_back('{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0});
  endtask

  // Entered just after a falling edge; leaves just after the next one.
  task automatic apply(input vec_t v, input string tag);
    if (v.rst) begin
      req_i = '0; last_i = '0; beat_i = 1'b0;
      reset = 1'b1;
      #1;
      chk({tag, " rst gnt"},  int'(gnt_o), 0);
      chk({tag, " rst id"},   int'(gnt_id_o), 0);
      chk({tag, " rst busy"}, int'(busy_o), 0);
      chk({tag, " rst rel"},  int'(release_o), 0);
      chk({tag, " rst to"},   int'(timeout_o), 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      req_i = v.req; last_i = v.last; beat_i = v.beat;
      @(posedge clk);
      #1;
      chk({tag, " gnt"},  int'(gnt_o), int'(v.gnt));
      chk({tag, " busy"}, int'(busy_o), int'(v.busy));
      chk({tag, " rel"},  int'(release_o), int'(v.rel));
      chk({tag, " to"},   int'(timeout_o), int'(v.to));
      if (v.busy) chk({tag, " id"}, int'(gnt_id_o), int'(v.id));
      chk({tag, " onehot"}, int'($onehot0(gnt_o)), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected under 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Two-port burst: port 0 sends three beats, then port 2 takes over with no gap.
    addrst();
    add(4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    add(4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    add(4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    add(4'b0101, 4'b0001, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // All ports requesting, single-beat bursts: rotation 0,1,2,3,0.
    addrst();
    add(4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
    add(4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    // Owner 1 abandons; non-owner req/last never preempt.
    addrst();
    add(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    add(4'b1010, 4'b1000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    add(4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    // Reset mid-burst with gnt=0010; afterwards ptr is back at 0.
    addrst();
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    add(4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    add(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);
    addrst();
    add(4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    add(4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);
    // Stalled owner 0: timeout after 16 beat-less OWN cycles, if enabled.
    addrst();
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++)
      add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
`else
    add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);
`endif
    for (int k = 0; k < 4; k++)
      add(4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b0);

    #2;
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Beat cap: port 2 alone, 16 beats without last. Releases after beat 8,
    // is re-granted immediately, and the count restarts so beat 16 releases again.
    begin
      vec_t v;
      v = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0};
      apply(v, "cap");
      v = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
      apply(v, "cap grant");
      for (int b = 1; b <= 16; b++) begin
        v = '{1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1,
              (b == 8 || b == 16), 1'b0};
        apply(v, $sformatf("cap beat%0d", b));
      end
      // Simultaneous last-beat and abandon: one release, not a timeout.
      v = '{1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
      apply(v, "cap drop");
      v = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
      apply(v, "cap idle");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
